timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
Main 64-bit up-counter stage of the timer IP, sitting directly downstream of the prescaler tick generator.
- Advances by one on each qualified cnt_en tick.
- Accepts software writes to the low and high 32-bit halves.
- Compares against a 64-bit compare value and raises a sticky interrupt status.
- Supports a debug halt handshake that freezes counting without losing state.

Parameters:
- DATA_W, 32, register-interface data width.
- CNT_W, 64, counter width; must equal 2*DATA_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- timer_en  in  1  timer enable from control register
- cnt_en  in  1  single-cycle count tick from prescaler stage
- wr_cnt_lo  in  1  write strobe, counter bits [31:0]
- wr_cnt_hi  in  1  write strobe, counter bits [63:32]
- wdata  in  DATA_W  write data for counter halves
- cmp_val  in  CNT_W  compare value from register block
- int_en  in  1  interrupt enable
- int_clr  in  1  write-1-to-clear pulse for int_st
- halt_req  in  1  debug halt request (level)
- cnt_val  out  CNT_W  current counter value (registered)
- int_st  out  1  sticky compare-match status
- tim_int  out  1  interrupt output = int_st & int_en
- halt_ack  out  1  high while counting is frozen

Behaviour:
- Reset: cnt_val=0, int_st=0, tim_int=0, halt_ack=0, FSM=RUN, timer_en_d=0.
- FSM states RUN, HALTED (registered, 1 bit):
  - RUN -> HALTED when halt_req=1; halt_ack goes 1 on the following cycle.
  - HALTED -> RUN when halt_req=0; halt_ack goes 0 on the following cycle.
  - The transition cycle itself counts normally: a tick in the same cycle halt_req rises is still applied.
- Counter update priority, highest first, one per cycle:
  - wr_cnt_lo/wr_cnt_hi: load wdata into the selected half; the other half holds. Both strobes together load wdata into both halves. Writes are accepted in any state, including HALTED and timer_en=0. A tick in the same cycle is dropped.
  - timer_en falling edge (timer_en_d=1, timer_en=0): cnt_val <= 0.
  - Increment: timer_en=1, cnt_en=1, FSM=RUN -> cnt_val <= cnt_val+1.
  - Otherwise hold.
- Wrap-around: 0xFFFF_FFFF_FFFF_FFFF + 1 -> 0. There is no carry flag.
- No halt-to-low carry hazard: the increment is a full 64-bit add in one cycle, with no split-half counting.
- Compare:
  - match = (cnt_val == cmp_val), evaluated on the registered cnt_val.
  - int_st is set on the clock edge after match is first true, i.e. 1 cycle after cnt_val reaches cmp_val.
  - int_st stays set while match persists; it is level-set, not edge-set.
- int_clr:
  - int_clr=1 with match=0: int_st <= 0 next cycle.
  - int_clr=1 with match=1: set dominates, int_st stays 1.
- tim_int is combinational AND of int_st and int_en. int_en=0 masks the output but does not clear int_st.
- timer_en=0 does not clear int_st. Only int_clr or reset clears it.
- Asynchronous reset mid-count returns all state to reset values immediately.

Decomposition:
- Shared package timer_pkg:
  - DATA_W and CNT_W constants.
  - FSM state typedef/encoding (ST_RUN=1'b0, ST_HALTED=1'b1).
  - The same package is used by the prescaler and register blocks.
- Sub-module timer_int_ctrl: holds the comparator, int_st set/clear logic and tim_int masking.
- The counter datapath and halt FSM stay in timer_counter.

Test Plan:
- Reset, then timer_en=1 with cnt_en pulsing every cycle for 5 cycles -> cnt_val=5; halt_ack=0; int_st=0.
- wr_cnt_hi=1, wdata=0xFFFFFFFF, then wr_cnt_lo=1, wdata=0xFFFFFFFE; one tick -> cnt_val=0xFFFFFFFF_FFFFFFFF; next tick -> 0 (wrap).
- cmp_val=0x10, int_en=1, ticks from 0:
  - cnt_val reaches 0x10 -> int_st=1 and tim_int=1 one cycle later.
  - Keep counting to 0x11, then pulse int_clr -> int_st=0.
  - int_clr while cnt_val==cmp_val -> int_st stays 1.
- halt_req=1 at cnt_val=7 with continuous ticks:
  - halt_ack=1 after 1 cycle; cnt_val freezes at 8.
  - wr_cnt_lo=0x100 during the halt -> cnt_val=0x100.
  - Drop halt_req -> counting resumes from 0x100.
- cnt_val=0x55, then drop timer_en -> cnt_val=0 next cycle; int_st unchanged; ticks ignored while timer_en=0.
- Same cycle wr_cnt_lo=0x20 and cnt_en=1 -> cnt_val=0x20 (write wins). Assert rst_n low mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer constants and halt FSM encoding, used by the counter, prescaler and register blocks.
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2 * DATA_W;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StHalted = 1'b1
  } halt_state_e;

endpackage

// File: rtl/timer_int_ctrl.sv
// Compare-match detection, sticky interrupt status and interrupt output masking.
module timer_int_ctrl #(
  parameter int unsigned CNT_W = timer_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             int_en,
  input  logic             int_clr,
  output logic             int_st,
  output logic             tim_int
);
  import timer_pkg::*;

  logic match;
  logic int_st_q, int_st_d;

  assign match = (cnt_val == cmp_val);

  // Level-set: a persisting match keeps re-setting status, so it beats a clear.
  always_comb begin
    int_st_d = int_st_q;
    if (match) begin
      int_st_d = 1'b1;
    end else if (int_clr) begin
      int_st_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_st_q <= 1'b0;
    end else begin
      int_st_q <= int_st_d;
    end
  end

  assign int_st  = int_st_q;
  assign tim_int = int_st_q & int_en;

endmodule

// File: rtl/timer_counter.sv
// 64-bit timer up-counter with software half-writes, debug halt handshake and compare interrupt.
module timer_counter #(
  parameter int unsigned DATA_W = timer_pkg::DATA_W,
  parameter int unsigned CNT_W  = timer_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              timer_en,
  input  logic              cnt_en,
  input  logic              wr_cnt_lo,
  input  logic              wr_cnt_hi,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CNT_W-1:0]  cmp_val,
  input  logic              int_en,
  input  logic              int_clr,
  input  logic              halt_req,
  output logic [CNT_W-1:0]  cnt_val,
  output logic              int_st,
  output logic              tim_int,
  output logic              halt_ack
);
  import timer_pkg::*;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  halt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timer_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (halt_req)  state_d = StHalted;
      StHalted: if (!halt_req) state_d = StRun;
    endcase
  end

  always_comb begin
    halt_ack = (state_q == StHalted);
  end

  // Writes win over everything, then the disable edge clear, then a qualified tick.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt_lo || wr_cnt_hi) begin
      if (wr_cnt_lo) cnt_d[DATA_W-1:0]     = wdata;
      if (wr_cnt_hi) cnt_d[CNT_W-1:DATA_W] = wdata;
    end else if (timer_en_q && !timer_en) begin
      cnt_d = '0;
    end else if (timer_en && cnt_en && (state_q == StRun)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      timer_en_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      timer_en_q <= timer_en;
    end
  end

  assign cnt_val = cnt_q;

  timer_int_ctrl #(
    .CNT_W(CNT_W)
  ) u_int_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_val (cnt_q),
    .cmp_val (cmp_val),
    .int_en  (int_en),
    .int_clr (int_clr),
    .int_st  (int_st),
    .tim_int (tim_int)
  );

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expectations queued with stimulus, checked after each cycle.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        timer_en = 1'b0;
  logic        cnt_en = 1'b0;
  logic        wr_cnt_lo = 1'b0;
  logic        wr_cnt_hi = 1'b0;
  logic [31:0] wdata = '0;
  logic [63:0] cmp_val = 64'h1234_5678_9ABC_DEF0;
  logic        int_en = 1'b0;
  logic        int_clr = 1'b0;
  logic        halt_req = 1'b0;
  logic [63:0] cnt_val;
  logic        int_st;
  logic        tim_int;
  logic        halt_ack;

  typedef struct {
    string       tag;
    logic [63:0] cnt;
    logic        st;
    logic        ti;
    logic        ha;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  timer_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .timer_en  (timer_en),
    .cnt_en    (cnt_en),
    .wr_cnt_lo (wr_cnt_lo),
    .wr_cnt_hi (wr_cnt_hi),
    .wdata     (wdata),
    .cmp_val   (cmp_val),
    .int_en    (int_en),
    .int_clr   (int_clr),
    .halt_req  (halt_req),
    .cnt_val   (cnt_val),
    .int_st    (int_st),
    .tim_int   (tim_int),
    .halt_ack  (halt_ack)
  );

  task automatic push_exp(input string tag, input logic [63:0] cnt, input logic st,
                          input logic ti, input logic ha);
    exp_t e;
    e.tag = tag; e.cnt = cnt; e.st = st; e.ti = ti; e.ha = ha;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    tests++;
    assert (cnt_val === e.cnt) else begin
      fails++;
      $error("FAIL %s cnt_val observed=%h expected=%h", e.tag, cnt_val, e.cnt);
    end
    tests++;
    assert (int_st === e.st) else begin
      fails++;
      $error("FAIL %s int_st observed=%b expected=%b", e.tag, int_st, e.st);
    end
    tests++;
    assert (tim_int === e.ti) else begin
      fails++;
      $error("FAIL %s tim_int observed=%b expected=%b", e.tag, tim_int, e.ti);
    end
    tests++;
    assert (halt_ack === e.ha) else begin
      fails++;
      $error("FAIL %s halt_ack observed=%b expected=%b", e.tag, halt_ack, e.ha);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the currently driven inputs, then compare against the queued expectation.
  task automatic cyc(input string tag, input logic [63:0] cnt, input logic st,
                     input logic ti, input logic ha);
    push_exp(tag, cnt, st, ti, ha);
    step();
    check_out();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 64'd0, 1'b0, 1'b0, 1'b0);
    check_out();
    rst_n = 1'b1;

    // Basic counting
    timer_en = 1'b1;
    cnt_en   = 1'b1;
    repeat (4) step();
    cyc("count5", 64'd5, 1'b0, 1'b0, 1'b0);
    cnt_en = 1'b0;

    // Half writes and wrap-around
    wr_cnt_hi = 1'b1; wdata = 32'hFFFF_FFFF;
    cyc("wr_hi", 64'hFFFF_FFFF_0000_0005, 1'b0, 1'b0, 1'b0);
    wr_cnt_hi = 1'b0; wr_cnt_lo = 1'b1; wdata = 32'hFFFF_FFFE;
    cyc("wr_lo", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    wr_cnt_lo = 1'b0; cnt_en = 1'b1;
    cyc("to_max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    cyc("wrap", 64'd0, 1'b0, 1'b0, 1'b0);

    // Compare match and sticky status
    cmp_val = 64'h10; int_en = 1'b1;
    repeat (15) step();
    cyc("reach_cmp", 64'h10, 1'b0, 1'b0, 1'b0);
    cnt_en = 1'b0;
    cyc("int_set", 64'h10, 1'b1, 1'b1, 1'b0);
    cnt_en = 1'b1;
    cyc("past_cmp", 64'h11, 1'b1, 1'b1, 1'b0);
    cnt_en = 1'b0; int_clr = 1'b1;
    cyc("clr_nomatch", 64'h11, 1'b0, 1'b0, 1'b0);
    int_clr = 1'b0; wr_cnt_lo = 1'b1; wdata = 32'h10;
    cyc("wr_to_cmp", 64'h10, 1'b0, 1'b0, 1'b0);
    wr_cnt_lo = 1'b0; int_clr = 1'b1;
    cyc("clr_match1", 64'h10, 1'b1, 1'b1, 1'b0);
    cyc("clr_match2", 64'h10, 1'b1, 1'b1, 1'b0);
    int_clr = 1'b0; int_en = 1'b0;
    push_exp("int_mask", 64'h10, 1'b1, 1'b0, 1'b0);
    #1;
    check_out();
    cmp_val = 64'h1234_5678_9ABC_DEF0; int_clr = 1'b1;
    cyc("clr_after", 64'h10, 1'b0, 1'b0, 1'b0);
    int_clr = 1'b0; int_en = 1'b1;

    // Debug halt handshake
    wr_cnt_lo = 1'b1; wdata = 32'd7;
    cyc("set7", 64'd7, 1'b0, 1'b0, 1'b0);
    wr_cnt_lo = 1'b0; cnt_en = 1'b1; halt_req = 1'b1;
    cyc("halt_edge", 64'd8, 1'b0, 1'b0, 1'b1);
    cyc("halt_frozen", 64'd8, 1'b0, 1'b0, 1'b1);
    wr_cnt_lo = 1'b1; wdata = 32'h100;
    cyc("halt_write", 64'h100, 1'b0, 1'b0, 1'b1);
    wr_cnt_lo = 1'b0; halt_req = 1'b0;
    cyc("unhalt", 64'h100, 1'b0, 1'b0, 1'b0);
    cyc("resume", 64'h101, 1'b0, 1'b0, 1'b0);
    cnt_en = 1'b0;

    // Disable edge clears count but not status
    cmp_val = 64'h55; wr_cnt_lo = 1'b1; wdata = 32'h55;
    cyc("set55", 64'h55, 1'b0, 1'b0, 1'b0);
    wr_cnt_lo = 1'b0;
    cyc("int55", 64'h55, 1'b1, 1'b1, 1'b0);
    timer_en = 1'b0; cnt_en = 1'b1;
    cyc("en_fall", 64'd0, 1'b1, 1'b1, 1'b0);
    cyc("en_off_tick", 64'd0, 1'b1, 1'b1, 1'b0);
    cnt_en = 1'b0; timer_en = 1'b1;
    cyc("en_on", 64'd0, 1'b1, 1'b1, 1'b0);

    // Write beats a same-cycle tick
    wr_cnt_lo = 1'b1; wdata = 32'h20; cnt_en = 1'b1;
    cyc("wr_vs_tick", 64'h20, 1'b1, 1'b1, 1'b0);
    wr_cnt_hi = 1'b1; wdata = 32'hA5A5_A5A5;
    cyc("wr_both", 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b1, 1'b0);
    wr_cnt_lo = 1'b0; wr_cnt_hi = 1'b0;
    repeat (2) step();
    cyc("count_on", 64'hA5A5_A5A5_A5A5_A5A8, 1'b1, 1'b1, 1'b0);
    halt_req = 1'b1;
    cyc("halt_again", 64'hA5A5_A5A5_A5A5_A5A9, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    push_exp("async_rst", 64'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_out();
    halt_req = 1'b0;
    rst_n = 1'b1;
    cyc("post_rst", 64'd1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
